// File: rtl/v_addsub_pipe.sv
// Pipelined unsigned adder/subtractor. The WIDTH-bit carry chain is cut into
// STAGES equal segments; stage k sums segment k with the carry registered by
// stage k-1, while the still-pending upper operand bits ride along in delay
// registers and the finished low segments are carried forward unchanged.
//
// Handshake: a beat moves on an edge where its VALID and READY are both high.
// Stage k may load whenever it is empty or stage k+1 is taking its beat, so
// ready ripples combinationally back from OUT_READY to IN_READY and bubbles
// collapse. A presented output beat holds RES/CO stable until OUT_READY=1.
module v_addsub_pipe #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned STAGES   = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             C,
   input  logic             CLR_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ADDSUB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] RES,
   output logic             CO
);
   localparam int unsigned SEG = WIDTH / STAGES;

   logic [STAGES-1:0] vld;
   logic [STAGES:0]   rdy;
   logic              top_c;
   logic              top_sub;
   logic              co_w;
   logic [WIDTH-1:0]  top_s;

   // Ready ripples back from OUT_READY; an empty stage can always load.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = OUT_READY;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         rdy[k] = ~vld[k] | rdy[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // Operand bits not yet summed when a beat enters this stage.
      localparam int unsigned REM = WIDTH - k * SEG;

      logic                 v_in;
      logic                 sub_in;
      logic                 c_in;
      logic [REM-1:0]       a_in;
      logic [REM-1:0]       b_in;
      logic [SEG:0]         seg_sum;
      logic [(k+1)*SEG-1:0] s_d;
      logic                 v_q;
      logic                 sub_q;
      logic                 c_q;
      logic [(k+1)*SEG-1:0] s_q;

      if (k == 0) begin : g_src
         // Subtraction is A + ~B + 1: invert B here and feed ADDSUB as carry-in.
         assign v_in   = IN_VALID;
         assign sub_in = ADDSUB;
         assign c_in   = ADDSUB;
         assign a_in   = A;
         assign b_in   = B ^ {WIDTH{ADDSUB}};
         assign s_d    = seg_sum[SEG-1:0];
      end else begin : g_src
         assign v_in   = g_st[k-1].v_q;
         assign sub_in = g_st[k-1].sub_q;
         assign c_in   = g_st[k-1].c_q;
         assign a_in   = g_st[k-1].g_ops.a_q;
         assign b_in   = g_st[k-1].g_ops.b_q;
         assign s_d    = {seg_sum[SEG-1:0], g_st[k-1].s_q};
      end

      assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};
      assign vld[k]  = v_q;

      // Stage register: partial sum, segment carry-out and op select advance together.
      always_ff @(posedge C or negedge CLR_N) begin
         if (!CLR_N) begin
            v_q   <= 1'b0;
            sub_q <= 1'b0;
            c_q   <= 1'b0;
            s_q   <= '0;
         end else if (rdy[k]) begin
            v_q <= v_in;
            if (v_in) begin
               sub_q <= sub_in;
               c_q   <= seg_sum[SEG];
               s_q   <= s_d;
            end
         end
      end

      if (REM > SEG) begin : g_ops
         logic [REM-SEG-1:0] a_q;
         logic [REM-SEG-1:0] b_q;

         // Delay registers for the operand bits that later segments still need.
         always_ff @(posedge C or negedge CLR_N) begin
            if (!CLR_N) begin
               a_q <= '0;
               b_q <= '0;
            end else if (rdy[k] && v_in) begin
               a_q <= a_in[REM-1:SEG];
               b_q <= b_in[REM-1:SEG];
            end
         end
      end
   end

   assign top_c     = g_st[STAGES-1].c_q;
   assign top_sub   = g_st[STAGES-1].sub_q;
   assign top_s     = g_st[STAGES-1].s_q;
   assign IN_READY  = rdy[0];
   assign OUT_VALID = vld[STAGES-1];

   // For subtraction a missing carry out of the top segment means a borrow.
   assign co_w = top_sub ? ~top_c : top_c;
   assign CO   = co_w;

   // Optional clamp toward the overflowed end: all-ones on add carry, zero on borrow.
   always_comb begin
      RES = top_s;
      if (SATURATE && co_w) begin
         RES = top_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
      end
   end

endmodule

// File: tb/tb_v_addsub_pipe.sv
// Bench for v_addsub_pipe: a wrapping and a saturating instance share all
// inputs. Directed vectors with hand-computed results feed a scoreboard.
module tb_v_addsub_pipe;
   localparam int W  = 16;
   localparam int ST = 4;
   localparam int NV = 20;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         in_ready_s;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         addsub;
   logic         out_valid;
   logic         out_valid_s;
   logic         out_ready;
   logic [W-1:0] res;
   logic [W-1:0] res_s;
   logic         co;
   logic         co_s;

   // Vector table: operands, op, wrapped result, flag, saturated result.
   logic [W-1:0] va  [NV];
   logic [W-1:0] vb  [NV];
   logic         vs  [NV];
   logic [W-1:0] vr  [NV];
   logic         vc  [NV];
   logic [W-1:0] vrs [NV];

   logic [W:0]   exp_q   [$];
   logic [W:0]   exp_s_q [$];
   logic [W:0]   cur_exp;
   logic [W:0]   cur_exp_s;
   logic         ready_rand;
   int           n_checks;
   int           n_fail;

   v_addsub_pipe #(.WIDTH(W), .STAGES(ST), .SATURATE(1'b0)) dut (
      .C(clk), .CLR_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
      .A(a), .B(b), .ADDSUB(addsub), .OUT_VALID(out_valid),
      .OUT_READY(out_ready), .RES(res), .CO(co)
   );

   v_addsub_pipe #(.WIDTH(W), .STAGES(ST), .SATURATE(1'b1)) dut_s (
      .C(clk), .CLR_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_s),
      .A(a), .B(b), .ADDSUB(addsub), .OUT_VALID(out_valid_s),
      .OUT_READY(out_ready), .RES(res_s), .CO(co_s)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: time %0t reached, summary not reached", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_beat(input int i);
      a         = va[i];
      b         = vb[i];
      addsub    = vs[i];
      cur_exp   = {vc[i], vr[i]};
      cur_exp_s = {vc[i], vrs[i]};
   endtask

   // Driver: present beat i from posedge+1 and hold it until accepted.
   task automatic send(input int i);
      int waited;
      set_beat(i);
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) chk("send_timeout", 32'(waited), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until every expected beat has come out; needs out_ready=1.
   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_s_q.size() != 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 32'(exp_q.size() + exp_s_q.size()), 32'd0);
   endtask

   // Random downstream readiness when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_rand) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard monitor: mid-cycle, compare any presented beat against the
   // queue head (pop on transfer), then record the beat being accepted.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid) begin
               if (exp_q.size() == 0) chk("unexpected_beat", 32'(out_valid), 32'd0);
               else begin
                  chk("res_wrap", 32'({co, res}), 32'(exp_q[0]));
                  if (out_ready) void'(exp_q.pop_front());
               end
            end
            if (out_valid_s) begin
               if (exp_s_q.size() == 0) chk("unexpected_beat_sat", 32'(out_valid_s), 32'd0);
               else begin
                  chk("res_sat", 32'({co_s, res_s}), 32'(exp_s_q[0]));
                  if (out_ready) void'(exp_s_q.pop_front());
               end
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(cur_exp);
               exp_s_q.push_back(cur_exp_s);
            end
         end
      end
   end

   // Main sequence
   initial begin
      int edges;
      int n_acc;
      logic full;

      va  = '{16'h00FF, 16'hFFFF, 16'h0003, 16'h1234, 16'h0000, 16'h8000, 16'h1234, 16'h0FFF, 16'h00F0, 16'hFFFF,
              16'h5555, 16'h1000, 16'h0000, 16'hABCD, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0001, 16'hC350, 16'h8001};
      vb  = '{16'h0001, 16'h0001, 16'h0005, 16'h1234, 16'h0001, 16'h8000, 16'h4321, 16'h0001, 16'h0010, 16'hFFFF,
              16'h1111, 16'h0001, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'h61A8, 16'h7FFF};
      vs  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vr  = '{16'h0100, 16'h0000, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0000, 16'h5555, 16'h1000, 16'h0100, 16'hFFFE,
              16'h4444, 16'h0FFF, 16'h0000, 16'hBE01, 16'hFFFF, 16'h0000, 16'h8000, 16'h0002, 16'h61A8, 16'h0000};
      vc  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vrs = '{16'h0100, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h5555, 16'h1000, 16'h0100, 16'hFFFF,
              16'h4444, 16'h0FFF, 16'h0000, 16'hBE01, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 16'h61A8, 16'hFFFF};

      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      addsub     = 1'b0;
      out_ready  = 1'b0;
      ready_rand = 1'b0;
      cur_exp    = '0;
      cur_exp_s  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_res_sat", 32'(res_s), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: count edges from the accepting edge (edge 1) to OUT_VALID
      out_ready = 1'b1;
      set_beat(0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("lat_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges = 1;
      @(negedge clk);
      while (!out_valid && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      chk("latency_edges", 32'(edges), 32'(ST));
      @(posedge clk);
      #1;
      drain();

      // Boundary vectors, full-rate downstream
      for (int i = 1; i < 5; i++) send(i);
      drain();

      // Stream of 100 beats, random gaps and random downstream readiness
      ready_rand = 1'b1;
      for (int p = 0; p < 5; p++) begin
         for (int i = 0; i < NV; i++) begin
            repeat ($urandom_range(0, 1)) begin
               @(posedge clk);
               #1;
            end
            send(i);
         end
      end
      ready_rand = 1'b0;
      out_ready  = 1'b1;
      drain();

      // Backpressure: fill with OUT_READY=0, hold, then release
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      n_acc = 0;
      full  = 1'b0;
      for (int i = 0; i <= ST && !full; i++) begin
         set_beat(5 + i);
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) n_acc++;
         else full = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("fill_count", 32'(n_acc), 32'(ST));
      repeat (10) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("release_in_ready", 32'(in_ready), 32'd1);
         chk("one_per_cycle", 32'(out_valid), 32'd1);
         @(posedge clk);
         #1;
         set_beat((10 + i) % NV);
      end
      in_valid = 1'b0;
      drain();

      // Reset mid-stream: fill, assert CLR_N between edges, expect nothing stale
      out_ready = 1'b0;
      for (int i = 0; i < ST; i++) send(i + 1);
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_valid_sat", 32'(out_valid_s), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_res", 32'({co, res}), 32'd0);
      exp_q.delete();
      exp_s_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(13);
      send(17);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
